// File: rtl/music_pkg.sv
// Shared types and sizes for the note sequencer slice.
// Imported by the interface, the synchroniser and the sequencer top.
package music_pkg;

  localparam int MAX_NOTES = 16;
  localparam int ADDR_W    = 4;

  typedef enum logic [2:0] {
    IDLE,
    REC_WRITE,
    REC_HOLD,
    PLAY_LOAD,
    PLAY_WAIT,
    PLAY_NOTE,
    PLAY_GAP
  } state_t;

endpackage

// File: rtl/note_sequencer_if.sv
// User controls in, datapath/tone strobes out.
// master = sequencer side, slave = datapath/user side.
interface note_sequencer_if;
  import music_pkg::*;

  logic              record_key;
  logic              play_start;
  logic              play_stop;
  logic              loop_en;
  logic [1:0]        tempo_sel;
  logic              ld_note;
  logic              ld_play;
  logic [ADDR_W-1:0] note_counter;
  logic              next_note_en;
  logic              audio_en;
  logic              playing;
  logic [ADDR_W:0]   note_count;

  modport master (
    input  record_key, play_start, play_stop,
    input  loop_en, tempo_sel,
    output ld_note, ld_play, note_counter,
    output next_note_en, audio_en, playing,
    output note_count
  );

  modport slave (
    output record_key, play_start, play_stop,
    output loop_en, tempo_sel,
    input  ld_note, ld_play, note_counter,
    input  next_note_en, audio_en, playing,
    input  note_count
  );

endinterface

// File: rtl/note_sequencer_sync.sv
// Two-flop synchroniser with a one-cycle rising-edge pulse.
// Module edge_sync; level is the synchronised input.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;

endmodule

// File: rtl/note_sequencer.sv
// Record/playback control for the note memory datapath.
// Records key presses as write strobes, replays them at a tempo.
module note_sequencer
  import music_pkg::*;
#(
  parameter int BEAT_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 2500000,
  parameter int READ_LAT    = 2,
  parameter int CNT_W       = 26
) (
  input logic clk,
  input logic reset,
  note_sequencer_if.master bus
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  beat_len;
  logic              ld_note, ld_play;
  logic              next_note_en, audio_en, playing;
  logic [ADDR_W-1:0] note_counter;
  logic [ADDR_W:0]   note_count;
  logic              rec_lvl, rec_rise;
  logic              play_lvl, play_rise;
  logic              stop_lvl, stop_rise;
  logic              in_play, more_notes;
  logic              unused_sync;

  edge_sync u_rec (
    .clk   (clk),
    .reset (reset),
    .d     (bus.record_key),
    .level (rec_lvl),
    .rise  (rec_rise)
  );

  edge_sync u_play (
    .clk   (clk),
    .reset (reset),
    .d     (bus.play_start),
    .level (play_lvl),
    .rise  (play_rise)
  );

  edge_sync u_stop (
    .clk   (clk),
    .reset (reset),
    .d     (bus.play_stop),
    .level (stop_lvl),
    .rise  (stop_rise)
  );

  assign unused_sync = ^{rec_lvl, play_lvl, stop_rise};

  assign beat_len = CNT_W'(BEAT_CYCLES) >> bus.tempo_sel;

  assign in_play = state inside {PLAY_LOAD, PLAY_WAIT,
                                 PLAY_NOTE, PLAY_GAP};

  assign more_notes = {1'b0, note_counter} < (note_count - 5'd1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      ld_note      <= 1'b0;
      ld_play      <= 1'b0;
      next_note_en <= 1'b0;
      audio_en     <= 1'b0;
      playing      <= 1'b0;
      note_counter <= '0;
      note_count   <= '0;
    end else begin
      ld_note      <= 1'b0;
      next_note_en <= 1'b0;
      if (in_play && stop_lvl) begin
        state    <= IDLE;
        ld_play  <= 1'b0;
        audio_en <= 1'b0;
        playing  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            // play has priority over a coincident record edge
            if (play_rise && note_count != '0) begin
              state        <= PLAY_LOAD;
              note_counter <= '0;
              cnt          <= CNT_W'(READ_LAT);
              ld_play      <= 1'b1;
              playing      <= 1'b1;
            end else if (rec_rise &&
                         note_count < (ADDR_W+1)'(MAX_NOTES)) begin
              state   <= REC_WRITE;
              ld_note <= 1'b1;
            end
          end
          REC_WRITE: begin
            note_count <= note_count + 5'd1;
            state      <= REC_HOLD;
          end
          REC_HOLD: state <= IDLE;
          PLAY_LOAD: begin
            if (cnt != '0) cnt <= cnt - 1'b1;
            state <= PLAY_WAIT;
          end
          PLAY_WAIT: begin
            if (cnt == '0) begin
              next_note_en <= 1'b1;
              audio_en     <= 1'b1;
              cnt          <= beat_len - 1'b1;
              state        <= PLAY_NOTE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          PLAY_NOTE: begin
            if (cnt == '0) begin
              audio_en <= 1'b0;
              cnt      <= CNT_W'(GAP_CYCLES - 1);
              state    <= PLAY_GAP;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          PLAY_GAP: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else if (more_notes) begin
              note_counter <= note_counter + 1'b1;
              cnt          <= CNT_W'(READ_LAT);
              state        <= PLAY_LOAD;
            end else if (bus.loop_en) begin
              note_counter <= '0;
              cnt          <= CNT_W'(READ_LAT);
              state        <= PLAY_LOAD;
            end else begin
              state   <= IDLE;
              ld_play <= 1'b0;
              playing <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.ld_note      = ld_note;
  assign bus.ld_play      = ld_play;
  assign bus.note_counter = note_counter;
  assign bus.next_note_en = next_note_en;
  assign bus.audio_en     = audio_en;
  assign bus.playing      = playing;
  assign bus.note_count   = note_count;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with short beat/gap timing.
// Each scenario task drives stimulus and checks inline.
module tb_note_sequencer;

  localparam int BEAT = 16;
  localparam int GAP  = 4;
  localparam int RLAT = 2;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  note_sequencer_if bus ();

  note_sequencer #(
    .BEAT_CYCLES (BEAT),
    .GAP_CYCLES  (GAP),
    .READ_LAT    (RLAT),
    .CNT_W       (26)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   ld_total;
  int   ld_dbl;
  logic p_ld;

  initial begin
    ld_total = 0;
    ld_dbl   = 0;
    p_ld     = 1'b0;
  end

  always @(negedge clk) begin
    if (bus.ld_note) ld_total = ld_total + 1;
    if (bus.ld_note && p_ld) ld_dbl = ld_dbl + 1;
    p_ld = bus.ld_note;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    repeat (3) tick;
    reset = 1'b1;
    tick;
  endtask

  task automatic press_record;
    bus.record_key = 1'b1;
    repeat (3) tick;
    bus.record_key = 1'b0;
    repeat (7) tick;
  endtask

  task automatic check_idle_zero(input string nm);
    logic [9:0] got;
    got = {bus.ld_note, bus.ld_play, bus.note_counter,
           bus.next_note_en, bus.audio_en, bus.playing,
           bus.note_count == 5'd0};
    checks++;
    if (got !== 10'b0000000001) begin
      $display("FAIL %s: outputs %b expected 0000000001", nm, got);
      errors++;
    end
  endtask

  task automatic test_reset;
    bus.record_key = 1'b0;
    bus.play_start = 1'b0;
    bus.play_stop  = 1'b0;
    bus.loop_en    = 1'b0;
    bus.tempo_sel  = 2'd0;
    reset = 1'b0;
    repeat (3) tick;
    check_idle_zero("reset_outputs");
    reset = 1'b1;
    repeat (2) tick;
    check_idle_zero("after_release");
  endtask

  task automatic test_record;
    int t0;
    t0 = ld_total;
    repeat (3) press_record;
    checks++;
    if (ld_total - t0 !== 3) begin
      $display("FAIL rec_pulses: got %0d expected 3", ld_total - t0);
      errors++;
    end
    checks++;
    if (ld_dbl !== 0) begin
      $display("FAIL rec_low_gap: wide pulses %0d expected 0", ld_dbl);
      errors++;
    end
    checks++;
    if (bus.note_count !== 5'd3) begin
      $display("FAIL rec_count: got %0d expected 3", bus.note_count);
      errors++;
    end
  endtask

  task automatic test_play(input logic [1:0] tsel, input int hi,
                           input string nm);
    int   upd_k, fall_k, hi_k;
    int   nn_cnt, nn_bad, hi_bad, gap_bad, runs;
    logic [3:0] seq[$];
    logic p_play, p_aud, p_nn, done, upd;
    logic [3:0] p_nc;
    upd_k = -100; fall_k = -100; hi_k = -100;
    nn_cnt = 0; nn_bad = 0; hi_bad = 0; gap_bad = 0; runs = 0;
    done = 1'b0;
    bus.tempo_sel  = tsel;
    bus.loop_en    = 1'b0;
    bus.play_start = 1'b1;
    p_play = bus.ld_play; p_aud = bus.audio_en;
    p_nn = bus.next_note_en; p_nc = bus.note_counter;
    for (int k = 0; k < 400 && !done; k++) begin
      tick;
      if (k == 3) bus.play_start = 1'b0;
      upd = bus.ld_play && (!p_play || bus.note_counter != p_nc);
      if (upd) begin
        if (runs > 0 && k - fall_k != GAP) gap_bad++;
        upd_k = k;
        seq.push_back(bus.note_counter);
      end
      if (bus.next_note_en) begin
        nn_cnt++;
        if (k - upd_k != RLAT + 1) nn_bad++;
        if (p_nn) nn_bad++;
      end
      if (bus.audio_en && !p_aud) hi_k = k;
      if (!bus.audio_en && p_aud) begin
        runs++;
        fall_k = k;
        if (k - hi_k != hi) hi_bad++;
      end
      if (!bus.ld_play && p_play) begin
        done = 1'b1;
        if (k - fall_k != GAP) gap_bad++;
      end
      p_play = bus.ld_play; p_aud = bus.audio_en;
      p_nn = bus.next_note_en; p_nc = bus.note_counter;
    end
    bus.play_start = 1'b0;
    checks++;
    if (!done) begin
      $display("FAIL %s_end: playback did not finish", nm);
      errors++;
    end
    checks++;
    if (seq.size() != 3 || seq[0] !== 4'd0 || seq[1] !== 4'd1 ||
        seq[2] !== 4'd2) begin
      $display("FAIL %s_seq: got %0d steps expected 0,1,2", nm,
               seq.size());
      errors++;
    end
    checks++;
    if (nn_cnt !== 3 || nn_bad !== 0) begin
      $display("FAIL %s_next: pulses %0d bad %0d expected 3/0", nm,
               nn_cnt, nn_bad);
      errors++;
    end
    checks++;
    if (runs !== 3 || hi_bad !== 0) begin
      $display("FAIL %s_audio: runs %0d bad %0d expected 3/0 len %0d",
               nm, runs, hi_bad, hi);
      errors++;
    end
    checks++;
    if (gap_bad !== 0) begin
      $display("FAIL %s_gap: bad gaps %0d expected 0", nm, gap_bad);
      errors++;
    end
    checks++;
    if (bus.ld_play !== 1'b0 || bus.playing !== 1'b0) begin
      $display("FAIL %s_idle: ld_play %b playing %b expected 0 0", nm,
               bus.ld_play, bus.playing);
      errors++;
    end
  endtask

  task automatic test_loop_stop;
    logic seen2, wrapped, got_nn;
    logic [3:0] p_nc;
    seen2 = 1'b0; wrapped = 1'b0; got_nn = 1'b0;
    bus.tempo_sel  = 2'd2;
    bus.loop_en    = 1'b1;
    bus.play_start = 1'b1;
    p_nc = bus.note_counter;
    for (int k = 0; k < 400 && !got_nn; k++) begin
      tick;
      if (k == 3) bus.play_start = 1'b0;
      if (bus.note_counter == 4'd2) seen2 = 1'b1;
      if (seen2 && p_nc == 4'd2 && bus.note_counter == 4'd0)
        wrapped = 1'b1;
      if (wrapped && bus.next_note_en) got_nn = 1'b1;
      p_nc = bus.note_counter;
    end
    bus.play_start = 1'b0;
    checks++;
    if (!wrapped || !got_nn) begin
      $display("FAIL loop_wrap: wrapped %b next %b expected 1 1",
               wrapped, got_nn);
      errors++;
    end
    bus.play_stop = 1'b1;
    repeat (2) tick;
    checks++;
    if (bus.playing !== 1'b1 || bus.audio_en !== 1'b1) begin
      $display("FAIL stop_early: playing %b audio %b expected 1 1",
               bus.playing, bus.audio_en);
      errors++;
    end
    tick;
    checks++;
    if ({bus.ld_play, bus.audio_en, bus.playing} !== 3'b000 ||
        bus.note_counter !== 4'd0) begin
      $display("FAIL stop_clear: lp/au/pl %b%b%b nc %0d expected 000 0",
               bus.ld_play, bus.audio_en, bus.playing, bus.note_counter);
      errors++;
    end
    bus.play_stop = 1'b0;
    bus.loop_en   = 1'b0;
    repeat (5) tick;
    checks++;
    if (bus.ld_play !== 1'b0 || bus.note_counter !== 4'd0) begin
      $display("FAIL stop_hold: ld_play %b nc %0d expected 0 0",
               bus.ld_play, bus.note_counter);
      errors++;
    end
  endtask

  task automatic test_simultaneous;
    int   t0;
    logic started;
    started = 1'b0;
    t0 = ld_total;
    bus.tempo_sel  = 2'd2;
    bus.play_start = 1'b1;
    bus.record_key = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick;
      if (k == 3) begin
        bus.play_start = 1'b0;
        bus.record_key = 1'b0;
      end
      if (bus.ld_play) started = 1'b1;
    end
    bus.play_start = 1'b0;
    bus.record_key = 1'b0;
    checks++;
    if (!started) begin
      $display("FAIL both_play: ld_play %b expected 1", started);
      errors++;
    end
    checks++;
    if (ld_total - t0 !== 0 || bus.note_count !== 5'd3) begin
      $display("FAIL both_norec: ld_note %0d count %0d expected 0 3",
               ld_total - t0, bus.note_count);
      errors++;
    end
    bus.play_stop = 1'b1;
    repeat (4) tick;
    bus.play_stop = 1'b0;
    repeat (2) tick;
  endtask

  task automatic test_reset_mid;
    logic hit;
    hit = 1'b0;
    bus.tempo_sel  = 2'd0;
    bus.play_start = 1'b1;
    for (int k = 0; k < 60 && !hit; k++) begin
      tick;
      if (k == 3) bus.play_start = 1'b0;
      if (bus.audio_en) hit = 1'b1;
    end
    bus.play_start = 1'b0;
    checks++;
    if (!hit) begin
      $display("FAIL mid_note: audio_en %b expected 1", hit);
      errors++;
    end
    reset = 1'b0;
    tick;
    check_idle_zero("reset_mid");
    reset = 1'b1;
    repeat (2) tick;
  endtask

  task automatic test_saturate;
    int t0;
    t0 = ld_total;
    repeat (17) press_record;
    checks++;
    if (ld_total - t0 !== 16) begin
      $display("FAIL sat_pulses: got %0d expected 16", ld_total - t0);
      errors++;
    end
    checks++;
    if (bus.note_count !== 5'd16) begin
      $display("FAIL sat_count: got %0d expected 16", bus.note_count);
      errors++;
    end
  endtask

  task automatic test_play_empty;
    int lp;
    lp = 0;
    do_reset;
    bus.play_start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick;
      if (k == 3) bus.play_start = 1'b0;
      if (bus.ld_play || bus.playing) lp++;
    end
    bus.play_start = 1'b0;
    checks++;
    if (lp !== 0) begin
      $display("FAIL empty_play: active cycles %0d expected 0", lp);
      errors++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    test_reset;
    test_record;
    test_play(2'd0, BEAT, "tempo0");
    test_play(2'd2, BEAT >> 2, "tempo2");
    test_loop_stop;
    test_simultaneous;
    test_reset_mid;
    test_saturate;
    test_play_empty;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Control stage directly upstream of the note-memory datapath.
- Turns user key events into write strobes during record. Steps the playback address through stored notes at a selectable tempo.
- Generates load/play strobes, current note index, VGA "next note" pulse and audio gate consumed by the datapath and tone output.
- Tracks stored-note count so playback covers only recorded slots.

Parameters:
- BEAT_CYCLES, 25000000, clk cycles per note at tempo_sel=0 (0.5 s at 50 MHz).
- GAP_CYCLES, 2500000, silent clk cycles between notes.
- READ_LAT, 2, cycles from note_counter change to valid memory read data.
- CNT_W, 26, width of duration counter; must hold BEAT_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-low reset
- record_key  in  1  level from store-note key, unsynchronised debounced level
- play_start  in  1  level, start playback
- play_stop  in  1  level, abort playback
- loop_en  in  1  1 = repeat sequence after last note
- tempo_sel  in  2  note duration = BEAT_CYCLES >> tempo_sel
- ld_note  out  1  one-cycle write strobe to datapath
- ld_play  out  1  high for whole playback; selects note_counter as memory address
- note_counter  out  4  current playback index
- next_note_en  out  1  one-cycle pulse when read data for note_counter is valid
- audio_en  out  1  tone gate, high only while a note sounds
- playing  out  1  high in any PLAY_* state
- note_count  out  5  stored notes, 0..16

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low, port reset.
- Reset (reset==0 at posedge): state IDLE, all outputs 0, note_count 0, counters 0. Reset mid-playback aborts the same edge.
- Inputs record_key and play_start get a 2-flop synchroniser and rising-edge detect. play_stop is level-sensitive after its 2-flop synchroniser.
- IDLE:
  - play_start edge with note_count>0 -> PLAY_LOAD, note_counter=0.
  - play_start edge with note_count==0 is ignored.
  - Else record_key edge with note_count<16 -> REC_WRITE.
  - Simultaneous play_start and record edges: play wins, record edge is dropped.
- REC_WRITE: ld_note=1 for exactly one cycle; note_count+1 -> REC_HOLD.
- REC_HOLD: ld_note=0 for one cycle (the datapath requires a low cycle between writes) -> IDLE.
- Record edge at note_count==16: ignored, no ld_note, count saturates. The datapath address wraps 15->0; the sequencer never lets the count exceed 16.
- PLAY_LOAD: ld_play=1 and held through every PLAY_* state; wait counter loaded with READ_LAT -> PLAY_WAIT.
- PLAY_WAIT: count down. At 0: next_note_en=1 for one cycle, audio_en=1, duration counter loaded with (BEAT_CYCLES>>tempo_sel)-1 -> PLAY_NOTE.
- PLAY_NOTE: audio_en=1 until the duration counter reaches 0 -> PLAY_GAP, audio_en=0, gap counter loaded with GAP_CYCLES-1.
- PLAY_GAP end:
  - If note_counter < note_count-1: note_counter+1 -> PLAY_LOAD.
  - Else if loop_en: note_counter=0 -> PLAY_LOAD.
  - Else -> IDLE.
  - loop_en is sampled only at this point.
- tempo_sel is sampled only when the duration counter loads; a change mid-note takes effect on the next note.
- play_stop high in any PLAY_* state -> IDLE at the next edge. On that edge ld_play, audio_en and playing clear. note_counter holds its last value.
- In IDLE, ld_play=0 and note_counter holds its value.
- All outputs are registered. next_note_en latency from note_counter update = READ_LAT+1 cycles.
- note_count is never cleared except by reset.

Decomposition:
- Shared package music_pkg:
  - state encoding localparams: IDLE, REC_WRITE, REC_HOLD, PLAY_LOAD, PLAY_WAIT, PLAY_NOTE, PLAY_GAP
  - MAX_NOTES=16
  - ADDR_W=4
- One sub-module, edge_sync: 2-flop synchroniser plus rising-edge pulse. Instantiated for record_key and play_start; its level output is used for play_stop.

Test Plan (BEAT_CYCLES=16, GAP_CYCLES=4, READ_LAT=2):
- Reset, then 3 record_key edges spaced 10 cycles -> exactly 3 one-cycle ld_note pulses, each followed by a low cycle; note_count=3.
- 3 notes stored, play_start, tempo_sel=0, loop_en=0:
  - note_counter steps 0,1,2.
  - next_note_en fires 3 cycles after each index change.
  - audio_en is high 16 cycles, then low 4 cycles.
  - Returns to IDLE with ld_play=0.
- Same sequence with tempo_sel=2 -> audio_en high 4 cycles per note. With loop_en=1, note_counter wraps 2->0 and playback continues until play_stop; stop clears audio_en/ld_play/playing within 1 cycle of the synchronised level.
- 17 record edges -> 16 ld_note pulses, note_count=16, 17th edge ignored. play_start with note_count=0 after reset -> remains IDLE, no ld_play.
- play_start and record_key rise in the same cycle -> playback starts, no ld_note, note_count unchanged.
- reset low during PLAY_NOTE -> next edge: all outputs 0, note_count 0, state IDLE.
